dms_cp_digital: RTL and testbench

- Digital charge-pump and loop-filter model at the consuming end of the PFD up/down interface.
- Integrates PFD up/down pulses sampled on refclk into an unsigned control code that stands in for the analog charge-pump output voltage. Full-scale code maps to 3.0 V.
- Reports lock, saturation and a stuck up&down condition (PFD reset path failure).
- Sits between the PFD and the VCO/DAC model in the CDR loop.

---
 rtl/dms_cp_digital.sv | 171 +++++++++++++++++
 tb/tb_dms_cp_digital.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dms_cp_digital.sv
// Digital charge-pump / loop-filter model: integrates synchronized PFD up/down
// pulses into an unsigned control code and reports lock, saturation and a
// stuck up&down condition.
module dms_cp_digital #(
    parameter int unsigned CODE_W    = 10,
    parameter int unsigned INIT_CODE = 512,
    parameter int unsigned KI        = 1,
    parameter int unsigned KP        = 8,
    parameter int unsigned LOCK_CNT  = 64,
    parameter int unsigned BOTH_MAX  = 4
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              down,
    output logic [CODE_W-1:0] cp_code,
    output logic              cp_valid,
    output logic              locked,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              both_err
);

    localparam int unsigned SUM_W = CODE_W + 2;
    localparam int unsigned Q_W   = $clog2(LOCK_CNT + 1);
    localparam int unsigned B_W   = $clog2(BOTH_MAX + 1);

    localparam logic [CODE_W-1:0]       MAX_CODE = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0]       INIT_V   = CODE_W'(INIT_CODE);
    localparam logic signed [SUM_W-1:0] MAX_S    = $signed({2'b00, MAX_CODE});
    localparam logic signed [SUM_W-1:0] KI_S     = SUM_W'(KI);
    localparam logic signed [SUM_W-1:0] KP_S     = SUM_W'(KP);
    localparam logic [Q_W-1:0]          LOCK_V   = Q_W'(LOCK_CNT);
    localparam logic [B_W-1:0]          BOTH_V   = B_W'(BOTH_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    logic r_en_m, r_en_s, r_up_m, r_up_s, r_dn_m, r_dn_s;

    logic [CODE_W-1:0] r_integ, r_code;
    logic [Q_W-1:0]    r_quiet;
    logic [B_W-1:0]    r_both;
    logic              r_valid, r_locked, r_sat_hi, r_sat_lo, r_both_err;

    logic                    w_single, w_both;
    logic signed [SUM_W-1:0] w_i_sum, w_c_sum, w_p;
    logic [CODE_W-1:0]       w_integ_upd, w_code_upd;
    logic [Q_W-1:0]          w_q_upd;
    logic [B_W-1:0]          w_b_upd;
    logic                    w_err_upd;

    logic [CODE_W-1:0] w_integ_next, w_code_next;
    logic [Q_W-1:0]    w_q_next;
    logic [B_W-1:0]    w_b_next;
    logic              w_err_next;

    // Two-flop synchronizers for the asynchronous PFD-side inputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_m <= 1'b0; r_en_s <= 1'b0;
            r_up_m <= 1'b0; r_up_s <= 1'b0;
            r_dn_m <= 1'b0; r_dn_s <= 1'b0;
        end else begin
            r_en_m <= en;   r_en_s <= r_en_m;
            r_up_m <= up;   r_up_s <= r_up_m;
            r_dn_m <= down; r_dn_s <= r_dn_m;
        end
    end

    // Integrator step, proportional kick and non-wrapping clamps
    always_comb begin
        w_single = r_up_s ^ r_dn_s;
        w_both   = r_up_s & r_dn_s;
        w_i_sum  = $signed({2'b00, r_integ});
        w_p      = '0;
        if (r_up_s && !r_dn_s) begin
            w_i_sum = w_i_sum + KI_S;
            w_p     = KP_S;
        end else if (r_dn_s && !r_up_s) begin
            w_i_sum = w_i_sum - KI_S;
            w_p     = -KP_S;
        end
        if (w_i_sum[SUM_W-1])    w_integ_upd = '0;
        else if (w_i_sum > MAX_S) w_integ_upd = MAX_CODE;
        else                      w_integ_upd = w_i_sum[CODE_W-1:0];
        w_c_sum = $signed({2'b00, w_integ_upd}) + w_p;
        if (w_c_sum[SUM_W-1])    w_code_upd = '0;
        else if (w_c_sum > MAX_S) w_code_upd = MAX_CODE;
        else                      w_code_upd = w_c_sum[CODE_W-1:0];
        w_q_upd   = w_single ? '0 : ((r_quiet == LOCK_V) ? r_quiet : r_quiet + Q_W'(1));
        w_b_upd   = !w_both ? '0 : ((r_both == BOTH_V) ? r_both : r_both + B_W'(1));
        w_err_upd = r_both_err | (w_b_upd == BOTH_V);
    end

    // Next state and next datapath values; IDLE values are the defaults
    always_comb begin
        w_state_next = r_state;
        w_integ_next = INIT_V;
        w_code_next  = INIT_V;
        w_q_next     = '0;
        w_b_next     = '0;
        w_err_next   = 1'b0;
        if (!r_en_s) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_next = S_TRACK;
                S_TRACK, S_LOCKED: begin
                    w_integ_next = w_integ_upd;
                    w_code_next  = w_code_upd;
                    w_q_next     = w_q_upd;
                    w_b_next     = w_b_upd;
                    w_err_next   = w_err_upd;
                    if (r_state == S_TRACK) begin
                        if (!w_single && (w_q_upd == LOCK_V) && !w_err_upd)
                            w_state_next = S_LOCKED;
                    end else if (w_single) begin
                        w_state_next = S_TRACK;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Registered datapath and status outputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_integ    <= INIT_V;
            r_code     <= INIT_V;
            r_quiet    <= '0;
            r_both     <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_sat_hi   <= 1'b0;
            r_sat_lo   <= 1'b0;
            r_both_err <= 1'b0;
        end else begin
            r_integ    <= w_integ_next;
            r_code     <= w_code_next;
            r_quiet    <= w_q_next;
            r_both     <= w_b_next;
            r_valid    <= (w_state_next != S_IDLE);
            r_locked   <= (w_state_next == S_LOCKED);
            r_sat_hi   <= (w_code_next == MAX_CODE);
            r_sat_lo   <= (w_code_next == '0);
            r_both_err <= w_err_next;
        end
    end

    assign cp_code  = r_code;
    assign cp_valid = r_valid;
    assign locked   = r_locked;
    assign sat_hi   = r_sat_hi;
    assign sat_lo   = r_sat_lo;
    assign both_err = r_both_err;

endmodule

// File: tb/tb_dms_cp_digital.sv
// Scoreboard bench for dms_cp_digital: stimulus pushes model predictions,
// a negedge monitor pops and compares them against the DUT.
module tb_dms_cp_digital;

    localparam int MAXC = 1023;
    localparam int INIT = 512;
    localparam int LAT  = 3;

    logic       refclk = 1'b0;
    logic       rst_n, en, up, down;
    logic [9:0] cp_code;
    logic       cp_valid, locked, sat_hi, sat_lo, both_err;

    dms_cp_digital dut (
        .refclk(refclk), .rst_n(rst_n), .en(en), .up(up), .down(down),
        .cp_code(cp_code), .cp_valid(cp_valid), .locked(locked),
        .sat_hi(sat_hi), .sat_lo(sat_lo), .both_err(both_err)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_act, m_lk, m_i, m_code, m_q, m_br, m_err;

    // Full-output scoreboard and targeted constant expectations
    int    mq_due[$];
    int    mq_val[$];
    int    dq_due[$];
    int    dq_kind[$];
    int    dq_val[$];
    string dq_nm[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int pack_out(input int code, input int v, input int l,
                                    input int h, input int lo, input int e);
        return (code << 5) | (v << 4) | (l << 3) | (h << 2) | (lo << 1) | e;
    endfunction

    function automatic int get_act(input int kind);
        case (kind)
            0: return int'(cp_code);
            1: return int'(cp_valid);
            2: return int'(locked);
            3: return int'(sat_hi);
            4: return int'(sat_lo);
            default: return int'(both_err);
        endcase
    endfunction

    task automatic model_reset();
        m_act = 0; m_lk = 0; m_i = INIT; m_code = INIT;
        m_q = 0; m_br = 0; m_err = 0;
    endtask

    // One sampled cycle of loop behaviour, in plain integer arithmetic
    task automatic model_step(input bit e, input bit u, input bit d);
        int p;
        if (!e) begin
            model_reset();
        end else if (m_act == 0) begin
            model_reset();
            m_act = 1;
        end else begin
            p = 0;
            if (u && !d) begin
                m_i = (m_i + 1 > MAXC) ? MAXC : m_i + 1;
                p = 8;
            end else if (d && !u) begin
                m_i = (m_i - 1 < 0) ? 0 : m_i - 1;
                p = -8;
            end
            m_code = m_i + p;
            if (m_code < 0) m_code = 0;
            if (m_code > MAXC) m_code = MAXC;
            if (u != d) begin
                m_q = 0;
                m_lk = 0;
            end else if (m_q < 64) begin
                m_q++;
            end
            m_br = (u && d) ? m_br + 1 : 0;
            if (m_br >= 4) m_err = 1;
            if (m_q >= 64 && m_err == 0) m_lk = 1;
        end
    endtask

    task automatic step(input bit e, input bit u, input bit d);
        @(negedge refclk);
        #1;
        en = e; up = u; down = d;
        model_step(e, u, d);
        mq_due.push_back(cyc + LAT);
        mq_val.push_back(pack_out(m_code, m_act, m_lk, int'(m_code == MAXC),
                                  int'(m_code == 0), m_err));
    endtask

    task automatic expect_at(input int due, input int kind, input int val, input string nm);
        dq_due.push_back(due);
        dq_kind.push_back(kind);
        dq_val.push_back(val);
        dq_nm.push_back(nm);
    endtask

    task automatic clear_q();
        mq_due.delete(); mq_val.delete();
        dq_due.delete(); dq_kind.delete(); dq_val.delete(); dq_nm.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_code"},  int'(cp_code),  INIT);
        chk({tag, "_valid"}, int'(cp_valid), 0);
        chk({tag, "_lock"},  int'(locked),   0);
        chk({tag, "_sathi"}, int'(sat_hi),   0);
        chk({tag, "_satlo"}, int'(sat_lo),   0);
        chk({tag, "_err"},   int'(both_err), 0);
    endtask

    // Monitor: compare due expectations on every falling edge
    always @(negedge refclk) begin
        if (rst_n) begin
            while (dq_due.size() > 0 && dq_due[0] <= cyc) begin
                if (dq_due[0] != cyc) chk({dq_nm[0], "_late"}, dq_due[0], cyc);
                else                  chk(dq_nm[0], get_act(dq_kind[0]), dq_val[0]);
                void'(dq_due.pop_front()); void'(dq_kind.pop_front());
                void'(dq_val.pop_front()); void'(dq_nm.pop_front());
            end
            while (mq_due.size() > 0 && mq_due[0] <= cyc) begin
                chk($sformatf("sb_due%0d", mq_due[0]),
                    pack_out(int'(cp_code), int'(cp_valid), int'(locked),
                             int'(sat_hi), int'(sat_lo), int'(both_err)),
                    mq_val[0]);
                void'(mq_due.pop_front()); void'(mq_val.pop_front());
            end
        end
    end

    initial begin
        int t, seg_len, mode;
        bit e, u, d;
        en = 1'b0; up = 1'b0; down = 1'b0; rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge refclk);
        chk_reset_vals("rst");
        #1 rst_n = 1'b1;

        // Single up pulse, then single down pulse
        repeat (10) step(1, 0, 0);
        step(1, 1, 0); t = cyc;
        expect_at(t + 3, 0, 521, "up_kick");
        expect_at(t + 4, 0, 513, "up_hold");
        expect_at(t + 5, 0, 513, "up_hold2");
        repeat (4) step(1, 0, 0);
        step(1, 0, 1); t = cyc;
        expect_at(t + 3, 0, 504, "dn_kick");
        expect_at(t + 4, 0, 512, "dn_hold");
        repeat (5) step(1, 0, 0);

        // Down ramp to the floor, release, then one up pulse
        repeat (600) step(1, 0, 1); t = cyc;
        expect_at(t + 3, 0, 0, "floor_code");
        expect_at(t + 3, 4, 1, "floor_satlo");
        step(1, 0, 0); t = cyc;
        expect_at(t + 3, 0, 0, "floor_rel");
        repeat (3) step(1, 0, 0);
        step(1, 1, 0); t = cyc;
        expect_at(t + 3, 0, 9, "floor_up_kick");
        expect_at(t + 3, 4, 0, "floor_up_satlo");
        expect_at(t + 4, 0, 1, "floor_up_hold");
        repeat (4) step(1, 0, 0);

        // Lock timing from TRACK entry, loss and reacquire
        repeat (4) step(0, 0, 0);
        step(1, 0, 0); t = cyc;
        expect_at(t + 2, 1, 0, "entry_valid0");
        expect_at(t + 3, 1, 1, "entry_valid1");
        expect_at(t + 66, 2, 0, "lock_early");
        expect_at(t + 67, 2, 1, "lock_rise");
        repeat (70) step(1, 0, 0);
        step(1, 1, 0); t = cyc;
        expect_at(t + 2, 2, 1, "unlock_hold");
        expect_at(t + 3, 2, 0, "unlock_fall");
        expect_at(t + 66, 2, 0, "relock_early");
        expect_at(t + 67, 2, 1, "relock_rise");
        repeat (70) step(1, 0, 0);

        // Both-high for 3 cycles (no error), then 4 cycles (error)
        step(1, 1, 1); t = cyc;
        step(1, 1, 1); step(1, 1, 1);
        expect_at(t + 5, 5, 0, "both3_err");
        expect_at(t + 6, 5, 0, "both3_err_rel");
        expect_at(t + 6, 0, 513, "both3_code");
        repeat (3) step(1, 0, 0);
        step(1, 1, 1); t = cyc;
        repeat (3) step(1, 1, 1);
        expect_at(t + 5, 5, 0, "both4_pre");
        expect_at(t + 6, 5, 1, "both4_set");
        expect_at(t + 12, 5, 1, "both4_sticky");
        repeat (10) step(1, 0, 0);
        step(0, 0, 0); t = cyc;
        expect_at(t + 2, 5, 1, "both_idle_pre");
        expect_at(t + 3, 5, 0, "both_idle_clr");
        expect_at(t + 3, 0, INIT, "both_idle_code");
        repeat (5) step(0, 0, 0);

        // Up ramp to ceiling, then en dropped while up is still held
        repeat (600) step(1, 1, 0); t = cyc;
        expect_at(t + 3, 0, MAXC, "ceil_code");
        expect_at(t + 3, 3, 1, "ceil_sathi");
        repeat (3) step(1, 1, 0);
        step(0, 1, 0); t = cyc;
        expect_at(t + 2, 1, 1, "endrop_valid1");
        expect_at(t + 2, 0, MAXC, "endrop_code_pre");
        expect_at(t + 3, 1, 0, "endrop_valid0");
        expect_at(t + 3, 0, INIT, "endrop_code");
        repeat (5) step(0, 1, 0);

        // Randomized segments
        for (int s = 0; s < 40; s++) begin
            mode    = $urandom_range(0, 5);
            seg_len = $urandom_range(5, 120);
            for (int k = 0; k < seg_len; k++) begin
                e = 1'b1; u = 1'b0; d = 1'b0;
                case (mode)
                    0: ;
                    1: begin u = ($urandom_range(0, 9) < 7); d = ($urandom_range(0, 9) < 1); end
                    2: begin d = ($urandom_range(0, 9) < 7); u = ($urandom_range(0, 9) < 1); end
                    3: begin u = $urandom_range(0, 1) != 0; d = $urandom_range(0, 1) != 0; end
                    4: begin u = 1'b1; d = 1'b1; end
                    default: begin
                        e = ($urandom_range(0, 9) < 7);
                        u = $urandom_range(0, 1) != 0;
                        d = $urandom_range(0, 1) != 0;
                    end
                endcase
                step(e, u, d);
            end
        end

        // Asynchronous reset in the middle of an up ramp
        repeat (5) step(1, 0, 0);
        repeat (50) step(1, 1, 0);
        @(negedge refclk);
        #2 rst_n = 1'b0;
        clear_q();
        model_reset();
        #1 chk_reset_vals("async_rst");
        repeat (2) @(negedge refclk);
        #1 rst_n = 1'b1;
        repeat (8) step(1, 0, 0);
        repeat (4) @(negedge refclk);
        chk("sb_drain", mq_due.size() + dq_due.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
